scan_display_ctrl: RTL

SCAN_DISPLAY_CTRL -- requirements
Module: scan_display_ctrl

---
 rtl/scan_display_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/scan_display_ctrl.sv
// rtl/scan_display_ctrl.sv - multiplexed seven-segment scan controller
// Prescaled digit scan with a frame-aligned input shadow, per-slot blanking and registered outputs.
module scan_display_ctrl #(
  parameter int N_DIGITS = 8,
  parameter int DIV      = 1000,
  parameter int BLANK    = 16
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_en,
  input  logic [N_DIGITS-1:0]     digit_en,
  output logic [7:0]              seg,
  output logic [N_DIGITS-1:0]     sel,
  output logic                    frame_start
);

  localparam int PW = $clog2(DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0]       DIV_M1  = PW'(DIV - 1);
  localparam logic [PW-1:0]       BLANK_P = PW'(BLANK);
  localparam logic [IW-1:0]       IDX_M1  = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ONE     = N_DIGITS'(1);

  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] val_q, val_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d;
  logic [N_DIGITS-1:0]   den_q, den_d;
  logic [7:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   sel_q, sel_d;
  logic                  fs_q, fs_d;

  logic       load;
  logic       dark;
  logic [3:0] nib;
  logic [7:0] glyph;

  function automatic logic [7:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 8'hFC;
      4'h1: decode = 8'h60;
      4'h2: decode = 8'hDA;
      4'h3: decode = 8'hF2;
      4'h4: decode = 8'h66;
      4'h5: decode = 8'hB6;
      4'h6: decode = 8'hBE;
      4'h7: decode = 8'hE0;
      4'h8: decode = 8'hFE;
      4'h9: decode = 8'hF6;
      4'hA: decode = 8'hEE;
      4'hB: decode = 8'h3E;
      4'hC: decode = 8'h1A;
      4'hD: decode = 8'h7A;
      4'hE: decode = 8'h9E;
      default: decode = 8'h8E;
    endcase
  endfunction

  always_comb begin
    pcnt_d = pcnt_q;
    idx_d  = idx_q;
    if (!enable) begin
      pcnt_d = '0;
      idx_d  = '0;
    end else if (pcnt_q == DIV_M1) begin
      pcnt_d = '0;
      idx_d  = (idx_q == IDX_M1) ? '0 : idx_q + 1'b1;
    end else begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  // The frame-start edge decodes from the freshly captured inputs so the
  // very first slot of a frame can never show the previous frame's data.
  always_comb begin
    load  = (pcnt_q == '0) && (idx_q == '0);
    val_d = load ? value    : val_q;
    dp_d  = load ? dp_en    : dp_q;
    den_d = load ? digit_en : den_q;
  end

  always_comb begin
    nib   = val_d[{idx_q, 2'b00} +: 4];
    glyph = decode(nib);
    dark  = !enable || (pcnt_q < BLANK_P) || !den_d[idx_q];
    seg_d = dark ? 8'h00 : {glyph[7:1], dp_d[idx_q]};
    sel_d = dark ? '1 : ~(ONE << idx_q);
    fs_d  = enable && load;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      idx_q  <= '0;
      val_q  <= '0;
      dp_q   <= '0;
      den_q  <= '0;
      seg_q  <= 8'h00;
      sel_q  <= '1;
      fs_q   <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      val_q  <= val_d;
      dp_q   <= dp_d;
      den_q  <= den_d;
      seg_q  <= seg_d;
      sel_q  <= sel_d;
      fs_q   <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign sel         = sel_q;
  assign frame_start = fs_q;

endmodule
